host_interface_burst: RTL and testbench

- Parametrised next-generation host-to-device register bridge between the GPIF-style host port (ctl/state/data) and the device interface (diEpAddr/diRegAddr/diWrite/diRead).
- Adds over the previous generation: configurable data/address widths, burst transfers with a length counter and optional register-address auto-increment, and a ready/valid read handshake with a one-word prefetch buffer.
- A sticky protocol-error flag and a per-burst word counter are also new.
- Tristate pads stay outside the block; data arrives and leaves as split in/out/oe buses.

---
 rtl/host_if_pkg.sv | 15 +
 rtl/host_if_burst_ctr.sv | 29 ++
 rtl/host_interface_burst.sv | 144 ++++++++++++++
 tb/tb_host_interface_burst.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/host_if_pkg.sv
// host_if_pkg: op codes, FSM state type and shared defaults for the host burst bridge.
package host_if_pkg;
   localparam int STATE_WIDTH_DEF = 4;
   localparam int OP_SETEP = 1;
   localparam int OP_SETREG = 2;
   localparam int OP_SETLEN = 3;
   localparam int OP_RDDATA = 4;
   localparam int OP_RESETRVAL = 5;
   localparam int OP_SETCFG = 6;
   localparam int OP_WRDATA = 7;
   typedef enum logic [3:0] {
      S_IDLE, S_SETEP, S_SETREG, S_SETLEN, S_RSTV, S_SETCFG, S_WR,
      S_RD_REQ, S_RD_WAIT, S_RD_HOLD, S_RD_DONE
   } fsm_t;
endpackage

// File: rtl/host_if_burst_ctr.sv
// host_if_burst_ctr: burst length counter and wrapping register-address incrementer.
module host_if_burst_ctr #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  if_clock,
   input  logic                  reset,
   input  logic                  load_addr,
   input  logic                  load_len,
   input  logic                  step,
   input  logic                  auto_inc,
   input  logic [ADDR_WIDTH-1:0] load_val,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic [ADDR_WIDTH-1:0] len,
   output logic                  burst_done
);
   always_ff @(posedge if_clock) begin
      if (reset) begin
         reg_addr <= '0;
         len <= '0;
         burst_done <= 1'b0;
      end else begin
         burst_done <= step && len == ADDR_WIDTH'(1);
         if (load_addr) reg_addr <= load_val;
         else if (step) reg_addr <= reg_addr + ADDR_WIDTH'(auto_inc);
         if (load_len) len <= load_val;
         else if (step && len != '0) len <= len - ADDR_WIDTH'(1);
      end
   end
endmodule

// File: rtl/host_interface_burst.sv
// host_interface_burst: GPIF-style host port to device register bridge with bursts and read prefetch.
module host_interface_burst
   import host_if_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int STATE_WIDTH = STATE_WIDTH_DEF,
   parameter bit AUTO_INC_DEFAULT = 1'b1
) (
   input  logic                   if_clock,
   input  logic                   reset,
   input  logic [2:0]             ctl,
   input  logic [STATE_WIDTH-1:0] state,
   input  logic [DATA_WIDTH-1:0]  data_in,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   data_oe,
   output logic                   rdy,
   output logic [ADDR_WIDTH-1:0]  diEpAddr,
   output logic [ADDR_WIDTH-1:0]  diRegAddr,
   output logic [DATA_WIDTH-1:0]  diRegDataIn,
   output logic                   diWrite,
   output logic                   diRead,
   output logic                   diReset,
   input  logic [DATA_WIDTH-1:0]  diRegDataOut,
   input  logic                   di_ready,
   input  logic                   di_rd_valid,
   output logic                   burst_done,
   output logic                   proto_err
);
   logic [STATE_WIDTH-1:0] state_q, state_prev;
   logic [2:0] ctl_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [ADDR_WIDTH-1:0] data_a, len;
   fsm_t fsm, nxt_op;
   logic change, strobe, step, last, load_addr, load_len;
   logic auto_inc, done, first, seen_rd, unused_ctl;
   assign unused_ctl = ^{ctl_q[2], ctl_q[0]};
   always_comb begin
      change = state_q != state_prev;
      strobe = ctl_q[1] && !change;
      data_a = ADDR_WIDTH'(data_q);
      nxt_op = state_q == STATE_WIDTH'(OP_SETEP) ? S_SETEP :
               state_q == STATE_WIDTH'(OP_SETREG) ? S_SETREG :
               state_q == STATE_WIDTH'(OP_SETLEN) ? S_SETLEN :
               state_q == STATE_WIDTH'(OP_RDDATA) ? S_RD_REQ :
               state_q == STATE_WIDTH'(OP_RESETRVAL) ? S_RSTV :
               state_q == STATE_WIDTH'(OP_SETCFG) ? S_SETCFG :
               state_q == STATE_WIDTH'(OP_WRDATA) ? S_WR : S_IDLE;
      load_addr = fsm == S_SETREG && strobe;
      load_len = fsm == S_SETLEN && strobe;
      step = !change && ((fsm == S_WR && diWrite) || (fsm == S_RD_HOLD && strobe));
      last = step && len == ADDR_WIDTH'(1);
   end
   host_if_burst_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_ctr (
      .if_clock(if_clock),
      .reset(reset),
      .load_addr(load_addr),
      .load_len(load_len),
      .step(step),
      .auto_inc(auto_inc),
      .load_val(data_a),
      .reg_addr(diRegAddr),
      .len(len),
      .burst_done(burst_done)
   );
   always_ff @(posedge if_clock) begin
      if (reset) begin
         state_q <= '0;
         state_prev <= '0;
         ctl_q <= '0;
         data_q <= '0;
         fsm <= S_IDLE;
         first <= 1'b0;
         done <= 1'b0;
         seen_rd <= 1'b0;
         auto_inc <= AUTO_INC_DEFAULT;
         diEpAddr <= '0;
         diRegDataIn <= '0;
         data_out <= '0;
         data_oe <= 1'b0;
         rdy <= 1'b0;
         diWrite <= 1'b0;
         diRead <= 1'b0;
         diReset <= 1'b0;
         proto_err <= 1'b0;
      end else begin
         state_q <= state;
         ctl_q <= ctl;
         data_q <= data_in;
         state_prev <= state_q;
         first <= change;
         diWrite <= 1'b0;
         diRead <= 1'b0;
         diReset <= 1'b0;
         if (di_rd_valid && seen_rd && !(fsm == S_RD_WAIT && !change)) proto_err <= 1'b1;
         if (change) begin
            fsm <= nxt_op;
            rdy <= 1'b0;
            data_oe <= 1'b0;
            done <= 1'b0;
         end else begin
            case (fsm)
               S_SETEP: begin
                  rdy <= 1'b1;
                  if (strobe) diEpAddr <= data_a;
               end
               S_SETREG, S_SETLEN: rdy <= 1'b1;
               S_SETCFG: begin
                  rdy <= 1'b1;
                  if (strobe) auto_inc <= data_q[0];
               end
               S_RSTV: begin
                  rdy <= 1'b1;
                  diReset <= first;
               end
               S_WR: begin
                  rdy <= di_ready && !done && !last;
                  done <= done | last;
                  if (strobe && rdy) begin
                     diWrite <= 1'b1;
                     diRegDataIn <= data_q;
                  end else if (strobe) proto_err <= 1'b1;
               end
               S_RD_REQ: if (di_ready) begin
                  diRead <= 1'b1;
                  seen_rd <= 1'b1;
                  fsm <= S_RD_WAIT;
               end
               S_RD_WAIT: if (di_rd_valid) begin
                  data_out <= diRegDataOut;
                  data_oe <= 1'b1;
                  rdy <= 1'b1;
                  fsm <= S_RD_HOLD;
               end
               S_RD_HOLD: if (strobe) begin
                  rdy <= 1'b0;
                  fsm <= len == ADDR_WIDTH'(1) ? S_RD_DONE : S_RD_REQ;
               end
               default: rdy <= 1'b0;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_host_interface_burst.sv
// tb_host_interface_burst: directed self-checking bench for host_interface_burst.
module tb_host_interface_burst;
   import host_if_pkg::*;
   logic if_clock = 1'b0;
   logic reset;
   logic [2:0] ctl;
   logic [3:0] state;
   logic [15:0] data_in, data_out, diEpAddr, diRegAddr, diRegDataIn, diRegDataOut;
   logic data_oe, rdy, diWrite, diRead, diReset, di_ready, di_rd_valid, burst_done, proto_err;
   int checks = 0;
   int failures = 0;
   int wr_cnt = 0, rd_cnt = 0, bd_cnt = 0, rst_cnt = 0;
   host_interface_burst dut (
      .if_clock(if_clock),
      .reset(reset),
      .ctl(ctl),
      .state(state),
      .data_in(data_in),
      .data_out(data_out),
      .data_oe(data_oe),
      .rdy(rdy),
      .diEpAddr(diEpAddr),
      .diRegAddr(diRegAddr),
      .diRegDataIn(diRegDataIn),
      .diWrite(diWrite),
      .diRead(diRead),
      .diReset(diReset),
      .diRegDataOut(diRegDataOut),
      .di_ready(di_ready),
      .di_rd_valid(di_rd_valid),
      .burst_done(burst_done),
      .proto_err(proto_err)
   );
   always #5 if_clock = ~if_clock;
   always @(negedge if_clock) begin
      if (diWrite) wr_cnt++;
      if (diRead) rd_cnt++;
      if (burst_done) bd_cnt++;
      if (diReset) rst_cnt++;
   end
   task automatic tick(input int n);
      repeat (n) @(posedge if_clock);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic strobe_word(input int val);
      data_in = 16'(val);
      ctl = 3'b010;
      tick(1);
      ctl = 3'b000;
      tick(1);
   endtask
   task automatic set_op(input int code, input int val);
      state = 4'(code);
      tick(2);
      strobe_word(val);
   endtask
   task automatic chk_reset_outs(input string tag);
      chk({tag, "_dout"}, 32'(data_out), 0);
      chk({tag, "_oe"}, 32'(data_oe), 0);
      chk({tag, "_rdy"}, 32'(rdy), 0);
      chk({tag, "_ep"}, 32'(diEpAddr), 0);
      chk({tag, "_reg"}, 32'(diRegAddr), 0);
      chk({tag, "_din"}, 32'(diRegDataIn), 0);
      chk({tag, "_strobes"}, {29'd0, diWrite, diRead, diReset}, 0);
      chk({tag, "_bd"}, 32'(burst_done), 0);
      chk({tag, "_err"}, 32'(proto_err), 0);
      chk({tag, "_autoinc"}, 32'(dut.auto_inc), 1);
   endtask
   initial begin
      int base_rd, base_bd;
      reset = 1'b1;
      ctl = '0;
      state = '0;
      data_in = '0;
      diRegDataOut = '0;
      di_ready = 1'b1;
      di_rd_valid = 1'b0;
      tick(3);
      chk_reset_outs("por");
      reset = 1'b0;
      tick(1);
      // register setup
      set_op(OP_SETEP, 16'h0003);
      chk("setep", 32'(diEpAddr), 32'h3);
      chk("setep_rdy", 32'(rdy), 1);
      set_op(OP_SETREG, 16'h0010);
      chk("setreg", 32'(diRegAddr), 32'h10);
      set_op(OP_SETCFG, 16'h0001);
      chk("setcfg", 32'(dut.auto_inc), 1);
      chk("setup_no_pulses", 32'(wr_cnt + rd_cnt), 0);
      state = 4'(OP_RESETRVAL);
      tick(5);
      chk("dreset_pulses", 32'(rst_cnt), 1);
      // write burst of three
      set_op(OP_SETLEN, 3);
      state = 4'(OP_WRDATA);
      tick(3);
      chk("wr_rdy", 32'(rdy), 1);
      strobe_word(16'h00A0);
      chk("wr0_strobe", 32'(diWrite), 1);
      chk("wr0_data", 32'(diRegDataIn), 32'hA0);
      chk("wr0_addr", 32'(diRegAddr), 32'h10);
      tick(1);
      strobe_word(16'h00A1);
      chk("wr1_data", 32'(diRegDataIn), 32'hA1);
      chk("wr1_addr", 32'(diRegAddr), 32'h11);
      tick(1);
      strobe_word(16'h00A2);
      chk("wr2_data", 32'(diRegDataIn), 32'hA2);
      chk("wr2_addr", 32'(diRegAddr), 32'h12);
      chk("wr2_bd_early", 32'(burst_done), 0);
      tick(1);
      chk("wr_bd", 32'(burst_done), 1);
      chk("wr_rdy_done", 32'(rdy), 0);
      tick(2);
      chk("wr_rdy_stays0", 32'(rdy), 0);
      chk("wr_count", 32'(wr_cnt), 3);
      chk("wr_bd_count", 32'(bd_cnt), 1);
      // back-pressure in an unbounded burst with auto-increment off
      set_op(OP_SETCFG, 0);
      chk("cfg_off", 32'(dut.auto_inc), 0);
      set_op(OP_SETLEN, 0);
      di_ready = 1'b0;
      state = 4'(OP_WRDATA);
      tick(3);
      chk("bp_rdy", 32'(rdy), 0);
      chk("bp_err_before", 32'(proto_err), 0);
      strobe_word(16'hBEEF);
      tick(1);
      chk("bp_err", 32'(proto_err), 1);
      chk("bp_no_write", 32'(wr_cnt), 3);
      chk("bp_addr", 32'(diRegAddr), 32'h13);
      di_ready = 1'b1;
      tick(1);
      strobe_word(16'h00C0);
      chk("nb_data", 32'(diRegDataIn), 32'hC0);
      tick(1);
      chk("noinc_addr", 32'(diRegAddr), 32'h13);
      strobe_word(16'h00C1);
      chk("mid_burst_write", 32'(diWrite), 1);
      // reset mid-burst
      reset = 1'b1;
      state = '0;
      tick(1);
      chk_reset_outs("midrst");
      reset = 1'b0;
      tick(1);
      // read burst of two
      set_op(OP_SETREG, 16'h0020);
      set_op(OP_SETLEN, 2);
      base_rd = rd_cnt;
      base_bd = bd_cnt;
      state = 4'(OP_RDDATA);
      tick(3);
      chk("rd0_req", 32'(diRead), 1);
      chk("rd0_addr", 32'(diRegAddr), 32'h20);
      tick(2);
      di_rd_valid = 1'b1;
      diRegDataOut = 16'h55AA;
      tick(1);
      di_rd_valid = 1'b0;
      chk("rd0_data", 32'(data_out), 32'h55AA);
      chk("rd0_rdy", 32'(rdy), 1);
      chk("rd0_oe", 32'(data_oe), 1);
      chk("rd0_err", 32'(proto_err), 0);
      strobe_word(0);
      chk("rd0_ack_rdy", 32'(rdy), 0);
      chk("rd0_ack_addr", 32'(diRegAddr), 32'h21);
      tick(1);
      chk("rd1_req", 32'(diRead), 1);
      tick(2);
      di_rd_valid = 1'b1;
      diRegDataOut = 16'h1234;
      tick(1);
      di_rd_valid = 1'b0;
      chk("rd1_data", 32'(data_out), 32'h1234);
      chk("rd1_rdy", 32'(rdy), 1);
      strobe_word(0);
      chk("rd_bd", 32'(burst_done), 1);
      chk("rd1_ack_addr", 32'(diRegAddr), 32'h22);
      tick(2);
      chk("rd_done_rdy", 32'(rdy), 0);
      chk("rd_done_oe", 32'(data_oe), 1);
      chk("rd_count", 32'(rd_cnt - base_rd), 2);
      chk("rd_bd_count", 32'(bd_cnt - base_bd), 1);
      // state change while waiting for read data
      set_op(OP_SETLEN, 0);
      state = 4'(OP_RDDATA);
      tick(4);
      di_rd_valid = 1'b1;
      diRegDataOut = 16'h0BAD;
      tick(1);
      di_rd_valid = 1'b0;
      chk("mr_oe", 32'(data_oe), 1);
      strobe_word(0);
      tick(1);
      chk("mr_req", 32'(diRead), 1);
      state = 4'(OP_SETREG);
      tick(2);
      chk("mr_rdy", 32'(rdy), 0);
      chk("mr_oe_drop", 32'(data_oe), 0);
      chk("mr_err_before", 32'(proto_err), 0);
      di_rd_valid = 1'b1;
      diRegDataOut = 16'hFFFF;
      tick(1);
      di_rd_valid = 1'b0;
      chk("mr_late_err", 32'(proto_err), 1);
      chk("mr_data_kept", 32'(data_out), 32'h0BAD);
      // late read data after reset is not an error
      state = 4'(OP_RDDATA);
      tick(3);
      chk("lr_req", 32'(diRead), 1);
      reset = 1'b1;
      state = '0;
      tick(1);
      reset = 1'b0;
      di_rd_valid = 1'b1;
      tick(1);
      di_rd_valid = 1'b0;
      tick(1);
      chk("lr_no_err", 32'(proto_err), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
